// File: rtl/oscope_capture_pkg.sv
// Shared types and register map for the oscilloscope capture buffer.
package oscope_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_e;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRETRIG  = 3'd1;
  localparam logic [2:0] OFF_STATUS   = 3'd2;
  localparam logic [2:0] OFF_TRIG_POS = 3'd3;
  localparam logic [2:0] OFF_THRESH   = 3'd4;

  localparam int CTRL_ARM    = 0;
  localparam int CTRL_EXT_EN = 1;
  localparam int CTRL_FORCE  = 2;
  localparam int CTRL_LVL_EN = 3;

endpackage

// File: rtl/capture_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port, same clock.
module capture_dpram #(
  parameter int AW = 13,
  parameter int DW = 16
) (
  input  logic          lb_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_q;

  // No reset so the array maps onto block RAM.
  always_ff @(posedge lb_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/oscope_capture_buf.sv
// Pre-trigger waveform capture buffer on the local bus.
// Define OSCOPE_CAPTURE_LEVEL_TRIG_EN to add the THRESH register and rising level trigger.
module oscope_capture_buf
  import oscope_capture_pkg::*;
#(
  parameter int AW       = 13,
  parameter int DW       = 16,
  parameter int READ_LAT = 2
) (
  input  logic          lb_clk,
  input  logic          reset,
  input  logic          lb_strobe,
  input  logic          lb_rd,
  input  logic          lb_write,
  input  logic [23:0]   lb_addr,
  input  logic [31:0]   lb_data,
  output logic [31:0]   lb_din,
  output logic          lb_din_valid,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  input  logic          trig_ext,
  output logic          done_irq
);

  localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};

  cap_state_e    r_state;
  logic [AW-1:0] r_wr_ptr, r_pretrig, r_pre_sh, r_trig_pos;
  logic [AW:0]   r_cnt;
  logic          r_ext_en, r_trig_d;

  logic          w_reg_sel, w_wr, w_rd, w_arm, w_force, w_lvl, w_trig, w_we;
  logic [2:0]    w_off;
  logic [AW:0]   w_cnt_inc, w_post_tgt;
  logic [AW-1:0] w_pretrig_clamp;
  logic [31:0]   w_reg_rd;
  logic [DW-1:0] w_ram_q;
  logic          w_unused_addr;

  assign w_reg_sel       = lb_addr[AW];
  assign w_off           = lb_addr[2:0];
  assign w_wr            = lb_strobe & lb_write & w_reg_sel;
  assign w_rd            = lb_strobe & lb_rd;
  assign w_arm           = w_wr & (w_off == OFF_CTRL) & lb_data[CTRL_ARM];
  assign w_force         = w_wr & (w_off == OFF_CTRL) & lb_data[CTRL_FORCE];
  assign w_trig          = w_force | (r_ext_en & trig_ext & ~r_trig_d) | w_lvl;
  assign w_we            = adc_valid & ~w_arm &
                           (r_state == ST_PRE || r_state == ST_ARMED || r_state == ST_POST);
  assign w_cnt_inc       = r_cnt + 1'b1;
  assign w_post_tgt      = DEPTH_W - {1'b0, r_pre_sh};
  assign w_pretrig_clamp = (|lb_data[31:AW]) ? {AW{1'b1}} : lb_data[AW-1:0];
  assign w_unused_addr   = ^lb_addr[23:AW+1];
  assign done_irq        = (r_state == ST_DONE);

`ifdef OSCOPE_CAPTURE_LEVEL_TRIG_EN
  logic [DW-1:0] r_thresh, r_prev;
  logic          r_prev_vld, r_lvl_en;

  // prev is the last valid sample since arm, regardless of capture phase.
  always_ff @(posedge lb_clk or posedge reset) begin
    if (reset) begin
      r_thresh   <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_lvl_en   <= 1'b0;
    end else begin
      if (w_wr && w_off == OFF_THRESH) r_thresh <= lb_data[DW-1:0];
      if (w_wr && w_off == OFF_CTRL)   r_lvl_en <= lb_data[CTRL_LVL_EN];
      if (w_arm) r_prev_vld <= 1'b0;
      else if (adc_valid) begin
        r_prev     <= adc_data;
        r_prev_vld <= 1'b1;
      end
    end
  end

  assign w_lvl = r_lvl_en & adc_valid & r_prev_vld &
                 ($signed(r_prev) <= $signed(r_thresh)) &
                 ($signed(adc_data) > $signed(r_thresh));
`else
  assign w_lvl = 1'b0;
`endif

  always_ff @(posedge lb_clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_pretrig  <= '0;
      r_pre_sh   <= '0;
      r_trig_pos <= '0;
      r_ext_en   <= 1'b0;
      r_trig_d   <= 1'b0;
    end else begin
      r_trig_d <= trig_ext;
      if (w_wr && w_off == OFF_CTRL)    r_ext_en  <= lb_data[CTRL_EXT_EN];
      if (w_wr && w_off == OFF_PRETRIG) r_pretrig <= w_pretrig_clamp;
      if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      // Arm overrides everything, including a trigger in the same cycle.
      if (w_arm) begin
        r_wr_ptr <= '0;
        r_cnt    <= '0;
        r_pre_sh <= r_pretrig;
        r_state  <= (r_pretrig == '0) ? ST_ARMED : ST_PRE;
      end else begin
        case (r_state)
          ST_PRE: if (adc_valid) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == {1'b0, r_pre_sh}) r_state <= ST_ARMED;
          end
          ST_ARMED: if (w_trig) begin
            r_trig_pos <= r_wr_ptr;
            r_cnt      <= {{AW{1'b0}}, adc_valid};
            r_state    <= (adc_valid && w_post_tgt == (AW+1)'(1)) ? ST_DONE : ST_POST;
          end
          ST_POST: if (adc_valid) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == w_post_tgt) r_state <= ST_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_reg_rd = '0;
    case (w_off)
      OFF_CTRL: begin
        w_reg_rd[CTRL_EXT_EN] = r_ext_en;
`ifdef OSCOPE_CAPTURE_LEVEL_TRIG_EN
        w_reg_rd[CTRL_LVL_EN] = r_lvl_en;
`endif
      end
      OFF_PRETRIG:  w_reg_rd[AW-1:0] = r_pretrig;
      OFF_STATUS:   w_reg_rd[AW+2:0] = {r_state, r_wr_ptr};
      OFF_TRIG_POS: w_reg_rd[AW-1:0] = r_trig_pos;
`ifdef OSCOPE_CAPTURE_LEVEL_TRIG_EN
      OFF_THRESH:   w_reg_rd = {{(32-DW){r_thresh[DW-1]}}, r_thresh};
`endif
      default: ;
    endcase
  end

  capture_dpram #(.AW(AW), .DW(DW)) u_ram (
    .lb_clk (lb_clk),
    .i_we   (w_we),
    .i_waddr(r_wr_ptr),
    .i_wdata(adc_data),
    .i_raddr(lb_addr[AW-1:0]),
    .o_rdata(w_ram_q)
  );

  // Stage 1 lines up register data with the RAM's registered output.
  logic [READ_LAT:1]      r_vld_pipe;
  logic                   r_reg_sel1;
  logic [31:0]            r_reg_q1;
  logic [READ_LAT:1][31:0] w_d;

  always_ff @(posedge lb_clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_reg_sel1 <= 1'b0;
      r_reg_q1   <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[READ_LAT-1:1], w_rd};
      if (w_rd) begin
        r_reg_sel1 <= w_reg_sel;
        r_reg_q1   <= w_reg_rd;
      end
    end
  end

  assign w_d[1] = r_reg_sel1 ? r_reg_q1 : {{(32-DW){w_ram_q[DW-1]}}, w_ram_q};

  genvar g;
  for (g = 2; g <= READ_LAT; g++) begin : g_rd
    logic [31:0] r_d;
    always_ff @(posedge lb_clk or posedge reset) begin
      if (reset) r_d <= '0;
      else if (r_vld_pipe[g-1]) r_d <= w_d[g-1];
    end
    assign w_d[g] = r_d;
  end

  assign lb_din       = w_d[READ_LAT];
  assign lb_din_valid = r_vld_pipe[READ_LAT];

endmodule

// File: doc/oscope_capture_buf.md
Name: oscope_capture_buf

Overview:
- Single-clock waveform capture buffer with pre-trigger support, living in the local-bus clock domain.
- Consumes the local-bus strobe/address/data produced by the board base block, and drives read data into the application's lb_din readback mux.
- Samples a DW-bit digitizer stream (already resynchronised to lb_clk) into a 2^AW circular RAM, stops after a trigger, and exposes the buffer and control/status registers on the local bus.

Parameters:
- AW, 13, buffer address width; depth = 2^AW samples.
- DW, 16, sample width (signed two's complement).
- READ_LAT, 2, cycles from read strobe to valid lb_din; minimum 2, fixed.

Ports:
- lb_clk  in  1  local-bus clock, sole clock.
- reset  in  1  async active-high reset.
- lb_strobe  in  1  bus cycle qualifier.
- lb_rd  in  1  read qualifier, valid with lb_strobe.
- lb_write  in  1  write qualifier, valid with lb_strobe.
- lb_addr  in  24  byte-free word address; bit AW selects registers (1) or buffer (0).
- lb_data  in  32  write data.
- lb_din  out  32  read data.
- lb_din_valid  out  1  one-cycle pulse aligned with lb_din.
- adc_data  in  DW  sample.
- adc_valid  in  1  sample enable.
- trig_ext  in  1  external trigger level; rising edge detected internally.
- done_irq  out  1  high while in DONE.

Behaviour:
- Reset: all outputs 0; state IDLE; wr_ptr=0; pretrig=0; trig_pos=0; ctrl=0.
- Register map (lb_addr[AW]=1, offset lb_addr[2:0]):
  - 0 CTRL: W bit0 arm (self-clearing pulse), bit1 ext_trig_en, bit2 force_trig (pulse); R bits1 only.
  - 1 PRETRIG: R/W, AW bits; written values above 2^AW-1 clamp to 2^AW-1.
  - 2 STATUS: R only, {state[2:0], wr_ptr[AW-1:0]}.
  - 3 TRIG_POS: R only, RAM address of the trigger sample.
  - 4 THRESH: see optional feature.
  - Offsets 5-7 read 0.
- Buffer region (lb_addr[AW]=0): reads RAM[lb_addr[AW-1:0]]. Data is sign-extended to 32 bits. Writes are ignored.
- Read timing:
  - A read is lb_strobe&lb_rd. lb_din and lb_din_valid appear exactly READ_LAT cycles later.
  - Back-to-back reads every cycle are allowed.
  - lb_din holds its value between reads.
- FSM: IDLE -> PRE -> ARMED -> POST -> DONE.
  - arm (any state): wr_ptr<=0, cnt<=0, go to PRE; if PRETRIG=0, go directly to ARMED.
  - PRE: each adc_valid writes RAM[wr_ptr], increments wr_ptr and cnt. When cnt reaches PRETRIG, go to ARMED. Triggers are ignored.
  - ARMED: writes continue circularly (wr_ptr wraps 2^AW-1 -> 0).
    - Trigger = force_trig | (ext_trig_en & rising trig_ext) [| level trigger].
    - On trigger: trig_pos<=wr_ptr (the address the trigger-cycle sample lands in, written only if adc_valid); cnt<=0; go to POST.
  - POST: writes continue until 2^AW-PRETRIG samples have been written since the trigger, including the trigger sample; then go to DONE.
  - DONE: no writes; done_irq=1. Only arm or reset leaves DONE.
- Simultaneous events:
  - arm and trigger in the same cycle: arm wins, trigger dropped.
  - A PRETRIG write during capture takes effect at next arm (shadowed on arm).
- Readback during capture returns live RAM contents; this is legal.
- Reset mid-capture returns to IDLE immediately; RAM contents are undefined and not cleared.

Optional Feature:
- Macro OSCOPE_CAPTURE_LEVEL_TRIG_EN.
- Defined:
  - THRESH register (offset 4, signed DW bits, R/W).
  - In ARMED, a trigger also fires on the first valid sample where prev<=THRESH and current>THRESH (signed compare).
  - Enabled by CTRL bit3.
- Undefined:
  - Offset 4 reads 0, writes ignored.
  - CTRL bit3 reads 0.
  - No comparator logic.

Decomposition:
- Package oscope_capture_pkg holds:
  - state enum (IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4);
  - register offset localparams;
  - CTRL bit indices.
- One sub-module: capture_dpram, a simple dual-port RAM (one write port, one registered read port, both lb_clk), inferred as block RAM.
- The top-level read pipeline adds READ_LAT-1 register stages.

Test Plan:
- Reset then read STATUS and TRIG_POS -> lb_din=0, lb_din_valid exactly 2 cycles after strobe.
- AW=4, PRETRIG=5, arm, ramp adc_data 0,1,2... every cycle, force_trig at sample 20:
  - TRIG_POS=20 mod 16=4;
  - DONE after 11 more samples, done_irq=1;
  - buffer reads (4-5+k) mod 16 hold values 15..30.
- PRETRIG=0, arm, ext_trig_en=1, pulse trig_ext:
  - IDLE->ARMED directly;
  - trigger captured on rising edge only; held-high trig_ext does not retrigger.
- Write PRETRIG=0xFFFFF -> reads back 2^AW-1.
- Arm and force_trig in the same write -> state PRE, TRIG_POS unchanged.
- Assert reset during POST -> state IDLE, done_irq=0 next cycle.
- With OSCOPE_CAPTURE_LEVEL_TRIG_EN and THRESH=-3, feed samples -5,-3,-2 -> trigger on -2.
- Without OSCOPE_CAPTURE_LEVEL_TRIG_EN, offset 4 reads 0.
